// File: rtl/lbc_pkg.sv
// Shared types and sizing helpers for the local data bus DMA sequencer.
package lbc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADLY  = 3'd1,
    ADDR  = 3'd2,
    DDLY  = 3'd3,
    DWAIT = 3'd4,
    HOLD  = 3'd5
  } lbc_state_t;

  localparam int LBC_AW    = 24;
  localparam int LBC_DW    = 16;
  // Delay counter width; APR_DLY and DAP_DLY must fit in it.
  localparam int LBC_CNT_W = 8;

  function automatic int lbc_occ_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [LBC_AW-1:0] addr;
    logic [LBC_DW-1:0] data;
  } lbc_wb_entry_t;

endpackage

// File: rtl/lbc_wbuf_fifo.sv
// DEPTH-entry write buffer FIFO; head entry is presented directly from storage.
module lbc_wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lbc_dma_sequencer.sv
// Sequences an external-bus DMA cycle onto the local data bus and buffers writes.
// Drain handshake: an entry leaves on any edge where wb_valid and wb_ready are both 1.
module lbc_dma_sequencer
  import lbc_pkg::*;
#(
  parameter int AW      = LBC_AW,
  parameter int DW      = LBC_DW,
  parameter int APR_DLY = 3,
  parameter int DAP_DLY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         sysclk,
  input  logic                         sys_rst,
  input  logic                         cgnt_n,
  input  logic                         bgnt_n,
  input  logic                         gnt_n,
  input  logic                         ibapr_n,
  input  logic                         bdap_n,
  input  logic                         mwrite_n,
  input  logic                         ebus_n,
  input  logic [AW-1:0]                bd_addr,
  input  logic [DW-1:0]                bd_data,
  output logic                         dbapr,
  output logic                         ebadr,
  output logic                         bact_n,
  output logic                         clkbd,
  output logic                         ebd_n,
  output logic                         bwait,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [AW-1:0]                wb_addr,
  output logic [DW-1:0]                wb_data,
  output logic [lbc_occ_w(DEPTH)-1:0]  wb_count,
  output lbc_state_t                   dbg_state
);

  localparam int CW = LBC_CNT_W;

  lbc_state_t     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [AW-1:0]  addr_lat, addr_nxt;
  logic           bact, bact_nxt;
  logic           ebadr_nxt, clkbd_nxt, bwait_nxt, ebd_n_nxt;
  logic           push, pop, full, empty;
  logic [AW+DW-1:0] head;

  assign pop       = wb_valid & wb_ready;
  assign wb_valid  = ~empty;
  assign bact_n    = ~bact;
  assign dbg_state = state;
  assign wb_addr   = head[AW+DW-1:DW];
  assign wb_data   = head[DW-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_lat;
    bact_nxt  = bact;
    bwait_nxt = bwait;
    clkbd_nxt = 1'b0;
    push      = 1'b0;
    ebadr_nxt = (ibapr_n & gnt_n) ? 1'b0 : ebadr;
    case (state)
      IDLE: if (!ibapr_n && (!gnt_n || !bgnt_n)) begin
        state_nxt = ADLY;
        cnt_nxt   = CW'(APR_DLY - 1);
        ebadr_nxt = 1'b1;
      end
      ADLY: begin
        if (ibapr_n) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          clkbd_nxt = 1'b1;
          addr_nxt  = bd_addr;
          state_nxt = ADDR;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ADDR: begin
        if (!bdap_n) begin
          if (!mwrite_n) begin
            state_nxt = DDLY;
            cnt_nxt   = CW'(DAP_DLY - 1);
          end else begin
            state_nxt = HOLD;
            bact_nxt  = 1'b1;
          end
        end else if (ibapr_n) begin
          state_nxt = IDLE;
        end
      end
      DDLY: begin
        if (cnt == '0) begin
          if (!full) begin
            push      = 1'b1;
            clkbd_nxt = 1'b1;
            state_nxt = HOLD;
          end else begin
            bwait_nxt = 1'b1;
            state_nxt = DWAIT;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DWAIT: if (!full || pop) begin
        push      = 1'b1;
        clkbd_nxt = 1'b1;
        bwait_nxt = 1'b0;
        state_nxt = HOLD;
      end
      HOLD: if (bdap_n && ibapr_n) begin
        bact_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Transceiver enable must not move while the 648 clock is high.
    ebd_n_nxt = clkbd ? ebd_n
                      : ~(~ebus_n & ((cgnt_n & gnt_n) | ~bgnt_n | bact));
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_lat <= '0;
      bact     <= 1'b0;
      ebadr    <= 1'b0;
      clkbd    <= 1'b0;
      bwait    <= 1'b0;
      ebd_n    <= 1'b1;
      dbapr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      addr_lat <= addr_nxt;
      bact     <= bact_nxt;
      ebadr    <= ebadr_nxt;
      clkbd    <= clkbd_nxt;
      bwait    <= bwait_nxt;
      ebd_n    <= ebd_n_nxt;
      dbapr    <= ~ibapr_n;
    end
  end

  lbc_wbuf_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_wbuf (
    .clk       (sysclk),
    .rst       (sys_rst),
    .push      (push),
    .push_data ({addr_lat, bd_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (wb_count)
  );

endmodule

// File: tb/tb_lbc_dma_sequencer.sv
// Directed bench for lbc_dma_sequencer: read, write, full buffer, wrap, abort, reset.
module tb_lbc_dma_sequencer;
  import lbc_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int APR_DLY = 3;
  localparam int DAP_DLY = 2;
  localparam int DEPTH = 4;

  logic sysclk = 1'b0, sys_rst = 1'b1;
  logic cgnt_n = 1'b1, bgnt_n = 1'b1, gnt_n = 1'b1;
  logic ibapr_n = 1'b1, bdap_n = 1'b1, mwrite_n = 1'b1, ebus_n = 1'b1;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic dbapr, ebadr, bact_n, clkbd, ebd_n, bwait, wb_valid;
  logic wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [2:0] wb_count;
  lbc_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW-1:0] exp_q[$];

  lbc_dma_sequencer #(.AW(AW), .DW(DW), .APR_DLY(APR_DLY), .DAP_DLY(DAP_DLY),
                      .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst), .cgnt_n(cgnt_n), .bgnt_n(bgnt_n),
    .gnt_n(gnt_n), .ibapr_n(ibapr_n), .bdap_n(bdap_n), .mwrite_n(mwrite_n),
    .ebus_n(ebus_n), .bd_addr(bd_addr), .bd_data(bd_data), .dbapr(dbapr),
    .ebadr(ebadr), .bact_n(bact_n), .clkbd(clkbd), .ebd_n(ebd_n),
    .bwait(bwait), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_count(wb_count),
    .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // driver tasks
  task automatic addr_phase(input logic [AW-1:0] a);
    gnt_n = 1'b0; ibapr_n = 1'b0; bd_addr = a;
    tick();
    check_vec("apr_ebadr", 64'(ebadr), 64'd1);
    repeat (APR_DLY - 1) begin
      tick();
      check_vec("apr_wait_clkbd", 64'(clkbd), 64'd0);
    end
    tick();
    check_vec("apr_clkbd", 64'(clkbd), 64'd1);
  endtask

  task automatic data_write(input logic [DW-1:0] d);
    mwrite_n = 1'b0; bdap_n = 1'b0; bd_data = d;
    repeat (DAP_DLY) begin
      tick();
      check_vec("ddly_clkbd", 64'(clkbd), 64'd0);
    end
    tick();
  endtask

  task automatic release_bus();
    bdap_n = 1'b1; ibapr_n = 1'b1; mwrite_n = 1'b1; gnt_n = 1'b1;
    tick();
    check_vec("release_idle", 64'(dbg_state), 64'(IDLE));
  endtask

  task automatic pop_check(input string tag);
    logic [AW+DW-1:0] e;
    e = exp_q.pop_front();
    check_vec(tag, 64'({wb_addr, wb_data}), 64'(e));
  endtask

  initial begin
    lbc_wb_entry_t ent;
    logic [AW+DW-1:0] e_hold;
    tick(); tick();
    sys_rst = 1'b0;
    check_vec("rst_state", 64'(dbg_state), 64'(IDLE));
    check_vec("rst_outs", 64'({ebadr, bact_n, clkbd, ebd_n, dbapr, bwait, wb_valid}), 64'b0101000);
    check_vec("rst_count", 64'(wb_count), 64'd0);

    // read cycle on bus grant, with ebd_n freeze on the clkbd cycle
    ebus_n = 1'b0; bgnt_n = 1'b0; ibapr_n = 1'b0;
    tick();
    check_vec("rd_ebadr", 64'(ebadr), 64'd1);
    check_vec("rd_dbapr", 64'(dbapr), 64'd1);
    check_vec("rd_ebd_on", 64'(ebd_n), 64'd0);
    tick(); check_vec("rd_e1_clkbd", 64'(clkbd), 64'd0);
    tick(); check_vec("rd_e2_clkbd", 64'(clkbd), 64'd0);
    tick(); check_vec("rd_e3_clkbd", 64'(clkbd), 64'd1);
    check_vec("rd_addr_state", 64'(dbg_state), 64'(ADDR));
    ebus_n = 1'b1;
    tick(); check_vec("rd_e4_clkbd", 64'(clkbd), 64'd0);
    check_vec("rd_ebd_frozen", 64'(ebd_n), 64'd0);
    tick(); check_vec("rd_ebd_off", 64'(ebd_n), 64'd1);
    bdap_n = 1'b0;
    tick(); check_vec("rd_bact", 64'(bact_n), 64'd0);
    tick(); check_vec("rd_bact_hold", 64'(bact_n), 64'd0);
    check_vec("rd_no_push", 64'(wb_count), 64'd0);
    bdap_n = 1'b1; ibapr_n = 1'b1;
    tick();
    check_vec("rd_bact_end", 64'(bact_n), 64'd1);
    check_vec("rd_idle", 64'(dbg_state), 64'(IDLE));
    check_vec("rd_ebadr_drop", 64'(ebadr), 64'd0);
    check_vec("rd_dbapr_drop", 64'(dbapr), 64'd0);
    bgnt_n = 1'b1;

    // single write then drain
    addr_phase(24'h001234);
    data_write(16'hBEEF);
    check_vec("wr_clkbd", 64'(clkbd), 64'd1);
    check_vec("wr_valid", 64'(wb_valid), 64'd1);
    check_vec("wr_addr", 64'(wb_addr), 64'h001234);
    check_vec("wr_data", 64'(wb_data), 64'hBEEF);
    check_vec("wr_count", 64'(wb_count), 64'd1);
    release_bus();
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
    check_vec("wr_drained", 64'(wb_count), 64'd0);
    check_vec("wr_valid_lo", 64'(wb_valid), 64'd0);

    // full buffer: four writes, fifth stalls until one drain slot
    for (int i = 0; i < 4; i++) begin
      addr_phase(24'h100000 + 24'(i));
      data_write(16'hA000 + 16'(i));
      check_vec("full_wr_clkbd", 64'(clkbd), 64'd1);
      ent.addr = 24'h100000 + 24'(i); ent.data = 16'hA000 + 16'(i);
      exp_q.push_back(ent);
      release_bus();
    end
    check_vec("full_count", 64'(wb_count), 64'd4);
    addr_phase(24'h100004);
    data_write(16'hA004);
    check_vec("full_no_clkbd", 64'(clkbd), 64'd0);
    check_vec("full_bwait", 64'(bwait), 64'd1);
    check_vec("full_dwait", 64'(dbg_state), 64'(DWAIT));
    tick();
    check_vec("full_still_wait", 64'(bwait), 64'd1);
    ent.addr = 24'h100004; ent.data = 16'hA004;
    wb_ready = 1'b1;
    pop_check("full_head0");
    exp_q.push_back(ent);
    tick(); wb_ready = 1'b0;
    check_vec("full_push_clkbd", 64'(clkbd), 64'd1);
    check_vec("full_bwait_drop", 64'(bwait), 64'd0);
    check_vec("full_count_same", 64'(wb_count), 64'd4);
    check_vec("full_hold", 64'(dbg_state), 64'(HOLD));
    release_bus();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_check("full_drain");
      tick();
    end
    wb_ready = 1'b0;
    check_vec("full_empty", 64'(wb_count), 64'd0);

    // pointer wrap: ten writes each drained immediately
    for (int i = 0; i < 10; i++) begin
      addr_phase(24'h200000 + 24'(i));
      data_write(16'(i));
      ent.addr = 24'h200000 + 24'(i); ent.data = 16'(i);
      exp_q.push_back(ent);
      check_vec("wrap_clkbd", 64'(clkbd), 64'd1);
      check_vec("wrap_count", 64'(wb_count), 64'd1);
      release_bus();
      pop_check("wrap_data");
      wb_ready = 1'b1;
      tick(); wb_ready = 1'b0;
      check_vec("wrap_empty", 64'(wb_count), 64'd0);
    end

    // abort during ADLY
    gnt_n = 1'b0; ibapr_n = 1'b0;
    tick();
    check_vec("ab_adly", 64'(dbg_state), 64'(ADLY));
    tick();
    ibapr_n = 1'b1;
    tick();
    check_vec("ab_idle", 64'(dbg_state), 64'(IDLE));
    check_vec("ab_ebadr_held", 64'(ebadr), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("ab_no_clkbd", 64'(clkbd), 64'd0);
    end
    gnt_n = 1'b1;
    tick();
    check_vec("ab_ebadr_drop", 64'(ebadr), 64'd0);

    // reset in DDLY with two entries buffered
    for (int i = 0; i < 2; i++) begin
      addr_phase(24'h300000 + 24'(i));
      data_write(16'hC000 + 16'(i));
      release_bus();
    end
    check_vec("rs_count2", 64'(wb_count), 64'd2);
    ebus_n = 1'b0; bgnt_n = 1'b0;
    addr_phase(24'h300002);
    check_vec("rs_pre_ebd", 64'(ebd_n), 64'd0);
    mwrite_n = 1'b0; bdap_n = 1'b0; bd_data = 16'hC002;
    tick();
    check_vec("rs_ddly", 64'(dbg_state), 64'(DDLY));
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check_vec("rs_state", 64'(dbg_state), 64'(IDLE));
    check_vec("rs_outs", 64'({ebadr, bact_n, clkbd, ebd_n, dbapr, bwait, wb_valid}), 64'b0101000);
    check_vec("rs_count", 64'(wb_count), 64'd0);
    ebus_n = 1'b1; bgnt_n = 1'b1;
    release_bus();
    e_hold = {24'h0ABCDE, 16'h1357};
    exp_q.delete();
    exp_q.push_back(e_hold);
    addr_phase(24'h0ABCDE);
    data_write(16'h1357);
    check_vec("rs_new_count", 64'(wb_count), 64'd1);
    pop_check("rs_new_entry");
    release_bus();
    wb_ready = 1'b1;
    tick(); wb_ready = 1'b0;
    check_vec("rs_new_drain", 64'(wb_count), 64'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
